// File: rtl/wb2reg_bridge.sv
// Wishbone slave to simple register-bus bridge: one outstanding access, with a
// bounded wait for reg_ack and a master-abort path that cancels the access.
module wb2reg_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'h0
) (
  input  logic        app_clk,
  input  logic        arst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [8:0]  wbs_adr_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [8:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a Wishbone request is taken when cyc&stb is high in IDLE; the
  // register side completes it with a one-cycle reg_ack while reg_cs is high.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [15:0] TERM_CNT = 16'(TIMEOUT_CYC - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic        cs_q;
  logic        wr_q;
  logic [8:0]  addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] dat_q;
  logic        ack_q;
  logic        err_q;

  always_ff @(posedge app_clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            addr_q  <= wbs_adr_i;
            wr_q    <= wbs_we_i;
            wdata_q <= wbs_dat_i;
            be_q    <= wbs_sel_i;
            cs_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          // Abort beats a coincident ack; ack beats the terminal count.
          if (!wbs_cyc_i) begin
            cs_q    <= 1'b0;
            state_q <= IDLE;
          end else if (reg_ack) begin
            cs_q    <= 1'b0;
            if (!wr_q) dat_q <= reg_rdata;
            ack_q   <= 1'b1;
            state_q <= RESP;
          end else if (cnt_q == TERM_CNT) begin
            cs_q    <= 1'b0;
            if (!wr_q) dat_q <= ERR_RDATA;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg_cs      = cs_q;
  assign reg_wr      = wr_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_be      = be_q;
  assign wbs_dat_o   = dat_q;
  assign wbs_ack_o   = ack_q;
  assign wbs_err_o   = err_q;
  assign dbg_state_o = state_q;

endmodule
